// File: rtl/pulse_pkg.sv
// Shared state encoding and default sizing for the pulse sequencer.
package pulse_pkg;

  localparam int CW_DEF    = 32;
  localparam int GUARD_DEF = 8;

  typedef enum logic [2:0] {IDLE, P1, D1, P2, TAIL} state_e;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// Load takes priority over decrement, and the count holds once it reaches zero.
module pulse_timer
  import pulse_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_seq.sv
// Repeating two-pulse sequencer (P1, gap, P2, tail) with receiver blanking; outputs are registered,
// first pulse one cycle after run; config is only taken in IDLE or on the last tail cycle.
module pulse_seq
  import pulse_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_p1,
  input  logic [CW-1:0] cfg_dly,
  input  logic [CW-1:0] cfg_p2,
  input  logic [CW-1:0] cfg_per,
  input  logic          run,
  output logic          pulse_out,
  output logic          blank_out,
  output logic          sync_out,
  output logic          busy,
  output logic          cfg_err
);

  state_e        state_q, state_d;
  logic [CW-1:0] sh_p1_q, sh_dly_q, sh_p2_q, sh_per_q;
  logic          sh_vld_q;
  logic [CW-1:0] act_dly_q, act_p2_q;
  logic [CW-1:0] guard_q, guard_d;
  logic          pulse_q, blank_q, sync_q, busy_q, err_q, rdy_en_q;

  logic [CW+1:0] span;
  logic          cfg_ok, accept, acc_ok, start, pulse_d;
  logic [CW-1:0] eff_p1, eff_dly, eff_p2, eff_per;
  logic          seg_ld, seg_en, seg_done, per_en, per_done;
  logic [CW-1:0] seg_val;

  // The segment timer paces P1/D1/P2; the period timer runs from each P1 rise.
  pulse_timer #(.CW(CW)) u_seg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (seg_ld),
    .load_val_i(seg_val),
    .en_i      (seg_en),
    .done_o    (seg_done)
  );

  pulse_timer #(.CW(CW)) u_per (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (start),
    .load_val_i(eff_per - CW'(1)),
    .en_i      (per_en),
    .done_o    (per_done)
  );

  assign cfg_ready = rdy_en_q && ((state_q == IDLE) || ((state_q == TAIL) && per_done));

  always_comb begin
    span    = {2'b00, cfg_p1} + {2'b00, cfg_dly} + {2'b00, cfg_p2};
    cfg_ok  = (cfg_p1 != '0) && (cfg_dly != '0) && (cfg_p2 != '0) && (span < {2'b00, cfg_per});
    accept  = cfg_valid && cfg_ready;
    acc_ok  = accept && cfg_ok;
    // A config accepted on the wrap cycle already governs the period that starts next.
    eff_p1  = acc_ok ? cfg_p1  : sh_p1_q;
    eff_dly = acc_ok ? cfg_dly : sh_dly_q;
    eff_p2  = acc_ok ? cfg_p2  : sh_p2_q;
    eff_per = acc_ok ? cfg_per : sh_per_q;

    state_d = state_q;
    start   = 1'b0;
    seg_ld  = 1'b0;
    seg_val = '0;
    case (state_q)
      IDLE: start = run && (sh_vld_q || acc_ok);
      P1: if (seg_done) begin
        state_d = D1;
        seg_ld  = 1'b1;
        seg_val = act_dly_q - CW'(1);
      end
      D1: if (seg_done) begin
        state_d = P2;
        seg_ld  = 1'b1;
        seg_val = act_p2_q - CW'(1);
      end
      P2: if (seg_done) state_d = TAIL;
      TAIL: if (per_done) begin
        state_d = IDLE;
        start   = run;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = P1;
      seg_ld  = 1'b1;
      seg_val = eff_p1 - CW'(1);
    end

    seg_en  = (state_q == P1) || (state_q == D1) || (state_q == P2);
    per_en  = (state_q != IDLE);
    pulse_d = (state_d == P1) || (state_d == P2);

    if (pulse_d) begin
      guard_d = '0;
    end else if (pulse_q) begin
      guard_d = CW'(GUARD);
    end else if (guard_q != '0) begin
      guard_d = guard_q - CW'(1);
    end else begin
      guard_d = guard_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_p1_q   <= '0;
      sh_dly_q  <= '0;
      sh_p2_q   <= '0;
      sh_per_q  <= '0;
      sh_vld_q  <= 1'b0;
      act_dly_q <= '0;
      act_p2_q  <= '0;
      guard_q   <= '0;
      pulse_q   <= 1'b0;
      blank_q   <= 1'b0;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      guard_q  <= guard_d;
      pulse_q  <= pulse_d;
      blank_q  <= pulse_d || (guard_d != '0);
      sync_q   <= start;
      busy_q   <= (state_d != IDLE);
      err_q    <= accept && !cfg_ok;
      if (acc_ok) begin
        sh_p1_q  <= cfg_p1;
        sh_dly_q <= cfg_dly;
        sh_p2_q  <= cfg_p2;
        sh_per_q <= cfg_per;
        sh_vld_q <= 1'b1;
      end
      if (start) begin
        act_dly_q <= eff_dly;
        act_p2_q  <= eff_p2;
      end
    end
  end

  assign pulse_out = pulse_q;
  assign blank_out = blank_q;
  assign sync_out  = sync_q;
  assign busy      = busy_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_pulse_seq.sv
// Bench for pulse_seq: directed scenarios plus random traffic, each cycle compared to a
// period-position reference model.
`timescale 1ns/1ps
module tb_pulse_seq;

  localparam int CW    = 32;
  localparam int GUARD = 8;
  localparam int FAR   = 1 << 20;

  logic          clk = 1'b0;
  logic          rst_n, cfg_valid, run;
  logic [CW-1:0] cfg_p1, cfg_dly, cfg_p2, cfg_per;
  logic          cfg_ready, pulse_out, blank_out, sync_out, busy, cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_seq #(.CW(CW), .GUARD(GUARD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_p1   (cfg_p1),
    .cfg_dly  (cfg_dly),
    .cfg_p2   (cfg_p2),
    .cfg_per  (cfg_per),
    .run      (run),
    .pulse_out(pulse_out),
    .blank_out(blank_out),
    .sync_out (sync_out),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: position within the current period plus a shadow config.
  bit       m_busy;
  int       m_pos, m_since;
  int       a_p1, a_dly, a_p2, a_per;
  bit       s_vld;
  int       s_p1, s_dly, s_p2, s_per;
  logic [5:0] exp_v;  // {pulse, blank, sync, busy, ready, err}
  wire  [5:0] obs_v = {pulse_out, blank_out, sync_out, busy, cfg_ready, cfg_err};

  task automatic model_step();
    bit     acc, ok, evld, strt, pl;
    int     e1, e2, e3, e4;
    longint span;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_pos   = 0;
      s_vld   = 1'b0;
      m_since = FAR;
      exp_v   = '0;
      return;
    end
    span = longint'(cfg_p1) + longint'(cfg_dly) + longint'(cfg_p2);
    ok   = (cfg_p1 >= 1) && (cfg_dly >= 1) && (cfg_p2 >= 1) && (span < longint'(cfg_per));
    acc  = cfg_valid && exp_v[1];
    if (acc && ok) begin
      e1 = int'(cfg_p1); e2 = int'(cfg_dly); e3 = int'(cfg_p2); e4 = int'(cfg_per);
    end else begin
      e1 = s_p1; e2 = s_dly; e3 = s_p2; e4 = s_per;
    end
    evld = s_vld || (acc && ok);
    strt = 1'b0;
    if (!m_busy) strt = run && evld;
    else if (m_pos == a_per - 1) begin
      if (run) strt = 1'b1;
      else m_busy = 1'b0;
    end else m_pos++;
    if (strt) begin
      m_busy = 1'b1; m_pos = 0;
      a_p1 = e1; a_dly = e2; a_p2 = e3; a_per = e4;
    end
    if (acc && ok) begin
      s_vld = 1'b1;
      s_p1 = int'(cfg_p1); s_dly = int'(cfg_dly); s_p2 = int'(cfg_p2); s_per = int'(cfg_per);
    end
    pl = m_busy && ((m_pos < a_p1) || ((m_pos >= a_p1 + a_dly) && (m_pos < a_p1 + a_dly + a_p2)));
    if (pl) m_since = 0;
    else if (exp_v[5]) m_since = 1;
    else if (m_since < FAR) m_since++;
    exp_v = {pl, pl || ((m_since >= 1) && (m_since <= GUARD)), strt, m_busy,
             !m_busy || (m_pos == a_per - 1), acc && !ok};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input int p1, input int dly, input int p2, input int per);
    cfg_p1 = CW'(p1); cfg_dly = CW'(dly); cfg_p2 = CW'(p2); cfg_per = CW'(per);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; set_cfg(0, 0, 0, 0);
    repeat (3) tick();
    n_checks++;
    if (obs_v !== 6'b000000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 000000", obs_v);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready=%b busy=%b want ready=1 busy=0", cfg_ready, busy);
    end
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v || busy !== 1'b0) begin
        n_fail++; $display("FAIL no_cfg_run cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_bad_cfg();
    set_cfg(5, 60, 5, 50); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL bad_cfg_err: got %b want %b (err=1)", obs_v, exp_v);
    end
    tick();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL bad_cfg_strobe: err=%b want 0", cfg_err);
    end
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v || busy !== 1'b0) begin
        n_fail++; $display("FAIL bad_cfg_idle cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_basic();
    int nsync, last, highs;
    set_cfg(5, 10, 10, 100); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    run = 1'b1;
    tick();
    n_checks++;
    if (sync_out !== 1'b1 || pulse_out !== 1'b1) begin
      n_fail++; $display("FAIL run_latency: sync=%b pulse=%b want 1 1", sync_out, pulse_out);
    end
    nsync = 1; last = 0; highs = 1;
    for (int i = 1; i < 300; i++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL basic cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
      if (pulse_out === 1'b1) highs++;
      if (sync_out === 1'b1) begin
        nsync++;
        n_checks++;
        if (i - last != 100) begin
          n_fail++; $display("FAIL sync_spacing: got %0d want 100", i - last);
        end
        last = i;
      end
    end
    n_checks++;
    if (nsync != 3 || highs != 45) begin
      n_fail++; $display("FAIL basic_totals: syncs=%0d highs=%0d want 3 45", nsync, highs);
    end
  endtask

  task automatic test_update();
    bit rdy, hit;
    int w;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL update_pre cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    set_cfg(3, 10, 10, 100); cfg_valid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      rdy = cfg_ready;
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL update_wait cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
      hit = rdy;
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (!hit || sync_out !== 1'b1) begin
      n_fail++; $display("FAIL update_wrap: handshake=%b sync=%b want 1 1", hit, sync_out);
    end
    w = 0;
    for (int k = 0; k < 20 && pulse_out === 1'b1; k++) begin
      w++;
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL update_p1 cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
    end
    n_checks++;
    if (w != 3) begin
      n_fail++; $display("FAIL update_width: got %0d want 3", w);
    end
  endtask

  task automatic test_stop();
    bit found;
    int n, syncs;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL stop_wait cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
      found = (sync_out === 1'b1);
    end
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      if (k == 30) run = 1'b0;
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL stop cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      if (busy === 1'b0) begin
        n = k;
        break;
      end
    end
    n_checks++;
    if (!found || n != 100) begin
      n_fail++; $display("FAIL stop_len: sync_seen=%b busy_fall=%0d want 1 100", found, n);
    end
    syncs = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sync_out === 1'b1) syncs++;
    end
    n_checks++;
    if (syncs != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_quiet: syncs=%0d busy=%b want 0 0", syncs, busy);
    end
  endtask

  task automatic test_guard();
    int b;
    set_cfg(3, 4, 3, 40); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    run = 1'b1;
    tick();
    b = 0;
    for (int k = 0; k < 60 && blank_out === 1'b1; k++) begin
      b++;
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL guard cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      tick();
    end
    n_checks++;
    if (b != 18) begin
      n_fail++; $display("FAIL guard_span: got %0d want 18", b);
    end
    run = 1'b0;
    for (int i = 0; i < 100 && busy === 1'b1; i++) tick();
    n_checks++;
    if (busy !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL guard_end: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(5, 10, 10, 100); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    run = 1'b1;
    repeat (18) tick();
    n_checks++;
    if (pulse_out !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL mid_p2: got %b want %b (pulse=1)", obs_v, exp_v);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL mid_reset: got %b want %b", obs_v, exp_v);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || obs_v !== exp_v) begin
        n_fail++; $display("FAIL mid_reset_idle cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      cfg_valid = ($urandom_range(0, 7) == 0);
      if (cfg_valid)
        set_cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(1, 30));
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    rst_n = 1'b1; cfg_valid = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bad_cfg();
    test_basic();
    test_update();
    test_stop();
    test_guard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pulse_seq.md
PULSE_SEQ -- requirements
Module: pulse_seq

Interface
REQ-001 Parameter CW, default 32: width of every timing field and internal counter.
REQ-002 Parameter GUARD, default 8: receiver-blanking hold-off, in clk cycles, after each pulse ends.
REQ-003 Port clk, input, 1: PLL output clock; sole clock. All logic on posedge clk.
REQ-004 Port rst_n, input, 1: synchronous active-low reset.
REQ-005 Port cfg_valid, input, 1: config word present.
REQ-006 Port cfg_ready, output, 1: config accepted this cycle when cfg_valid and cfg_ready are both high.
REQ-007 Port cfg_p1, input, CW: first pulse width, in cycles.
REQ-008 Port cfg_dly, input, CW: gap from P1 falling edge to P2 rising edge.
REQ-009 Port cfg_p2, input, CW: second pulse width.
REQ-010 Port cfg_per, input, CW: repetition period, in cycles, measured from P1 rise.
REQ-011 Port run, input, 1: level-sensitive enable for the repeating sequence.
REQ-012 Port pulse_out, output, 1: RF gate to pin.
REQ-013 Port blank_out, output, 1: receiver blanking.
REQ-014 Port sync_out, output, 1: one-cycle strobe at each period start.
REQ-015 Port busy, output, 1: state is not IDLE.
REQ-016 Port cfg_err, output, 1: one-cycle strobe when a config is rejected.

Function
REQ-017 States: IDLE, P1, D1, P2, TAIL.
REQ-018 Transitions: IDLE->P1 when run=1 and a valid config is loaded; P1->D1 after cfg_p1 cycles; D1->P2 after cfg_dly cycles; P2->TAIL after cfg_p2 cycles; TAIL->P1 when the period count reaches cfg_per and run=1; TAIL->IDLE when the period count reaches cfg_per and run=0.
REQ-019 Latency: run sampled high at cycle N in IDLE -> pulse_out=1 and sync_out=1 at cycle N+1.
REQ-020 pulse_out = 1 exactly in P1 and P2 (registered); each pulse is exactly its programmed width, high-to-low.
REQ-021 Each period is exactly cfg_per cycles from rising edge to rising edge of P1.
REQ-022 blank_out = 1 in P1 and P2, and for GUARD cycles after each pulse falls; the guard is truncated if the next pulse begins first (blank simply stays high).
REQ-023 Config validity: cfg_p1>=1, cfg_p2>=1, cfg_dly>=1, and cfg_p1+cfg_dly+cfg_p2 < cfg_per. The sum is computed at CW+2 bits, so no wrap.
REQ-024 An invalid config is dropped; cfg_err pulses for 1 cycle; the active config is unchanged.
REQ-025 cfg_ready = 1 in IDLE and during the last cycle of TAIL; otherwise 0.
REQ-026 An accepted config goes to the shadow register and takes effect at the next P1 entry; a sequence in progress is never altered mid-period.
REQ-027 If no valid config has ever been loaded, run is ignored and the block stays in IDLE.
REQ-028 run deasserted mid-period: the current period completes, including TAIL, then the block goes to IDLE.
REQ-029 Simultaneous config acceptance and period wrap: the new config applies to the period starting next cycle.
REQ-030 Counters are CW-bit down-counters loaded with (value-1); reload occurs on each state entry.

Reset
REQ-031 rst_n=0 at a clock edge forces state to IDLE, pulse_out=0, blank_out=0, sync_out=0, busy=0, cfg_err=0, cfg_ready=0 during reset, shadow invalid, and all counters to 0.
REQ-032 Reset asserted mid-pulse drops pulse_out at the following edge; no partial config survives.
REQ-033 cfg_ready is 1 on the first cycle after rst_n rises.

Structure
REQ-034 Package pulse_pkg holds the state enum (IDLE, P1, D1, P2, TAIL) and the default CW/GUARD constants.
REQ-035 One sub-module, pulse_timer: a loadable CW-bit down-counter with a done flag, instantiated for the segment and period counts.

Verification
REQ-036 Config p1=5, dly=10, p2=10, per=100, run held high -> pulse_out high for cycles 1-5, low for 6-15, high for 16-25; sync_out every 100 cycles, repeated over 3 periods.
REQ-037 Config p1=5, dly=60, p2=5, per=50 -> cfg_err for 1 cycle, no cfg handshake effect; run then stays IDLE (busy=0).
REQ-038 Running with per=100; new config p1=3 presented mid-period -> current period unchanged, next P1 is 3 cycles wide.
REQ-039 run dropped at cycle 30 of a 100-cycle period -> busy falls after cycle 100, no further sync_out.
REQ-040 GUARD=8, dly=4 -> blank_out held continuously from P1 rise to 8 cycles after P2 fall.
REQ-041 rst_n low during P2 -> pulse_out=0 at next edge, state IDLE, prior config discarded (run ignored until reload).
